// File: rtl/forte_soc_pkg.sv
// -----------------------------------------------------------------------------
// forte_soc_pkg
//   Shared types and constants for the forte_soc data-bus fabric.
//   - bus_tgt_e            : destination of a core data-port transaction
//   - PERIPH_*_DEFAULT     : default peripheral/eFPGA MMIO window
//   - decode_tgt()         : address -> target decode (RAM wins on overlap)
// -----------------------------------------------------------------------------
package forte_soc_pkg;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_PER,
    TGT_ERR
  } bus_tgt_e;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PERIPH_MASK_DEFAULT = 32'hFFFF_F000;

  // RAM occupies every address whose bits above the RAM window are zero.
  // RAM is tested first so it takes priority if the windows overlap.
  function automatic bus_tgt_e decode_tgt(
    input logic [31:0] addr,
    input int unsigned ram_addr_width,
    input logic [31:0] periph_base,
    input logic [31:0] periph_mask
  );
    if ((addr >> ram_addr_width) == 32'd0) begin
      return TGT_RAM;
    end else if ((addr & periph_mask) == periph_base) begin
      return TGT_PER;
    end else begin
      return TGT_ERR;
    end
  endfunction

endpackage : forte_soc_pkg

// File: rtl/data_bus_router.sv
// -----------------------------------------------------------------------------
// data_bus_router
//   Routes the Ibex core data port (req/gnt/rvalid) to the shared RAM data
//   port or to the peripheral/eFPGA MMIO port. Unmapped addresses are
//   answered internally with a one-cycle error response. Responses return
//   strictly in request order: a new request only issues when the pipe is
//   empty or it goes to the same target as the transactions already in
//   flight, so a target switch waits for the previous target to drain.
//
// Ports
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   m_*                            core side: req/gnt, addr/we/be/wdata,
//                                  rvalid/rdata/err response
//   ram_*                          RAM side: req/gnt, word-window address,
//                                  we/be/wdata pass-through, rvalid/rdata
//   per_*                          peripheral side: req/gnt, full address,
//                                  we/be/wdata pass-through, rvalid/rdata/err
//   outstanding_o                  granted-but-unanswered transaction count
//   proto_err_o                    sticky: slave response nobody asked for
// -----------------------------------------------------------------------------
module data_bus_router
  import forte_soc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter logic [31:0] PERIPH_BASE     = PERIPH_BASE_DEFAULT,
  parameter logic [31:0] PERIPH_MASK     = PERIPH_MASK_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m_req_i,
  output logic                  m_gnt_o,
  input  logic [31:0]           m_addr_i,
  input  logic                  m_we_i,
  input  logic [3:0]            m_be_i,
  input  logic [31:0]           m_wdata_i,
  output logic                  m_rvalid_o,
  output logic [31:0]           m_rdata_o,
  output logic                  m_err_o,

  output logic                  ram_req_o,
  input  logic                  ram_gnt_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic                  ram_rvalid_i,
  input  logic [31:0]           ram_rdata_i,

  output logic                  per_req_o,
  input  logic                  per_gnt_i,
  output logic [31:0]           per_addr_o,
  output logic                  per_we_o,
  output logic [3:0]            per_be_o,
  output logic [31:0]           per_wdata_o,
  input  logic                  per_rvalid_i,
  input  logic [31:0]           per_rdata_i,
  input  logic                  per_err_i,

  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  proto_err_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_count;        // granted, response not yet returned
  bus_tgt_e         r_tgt;          // target of the transactions in flight
  logic             r_err_pending;  // internal error response due this cycle
  logic             r_proto_err;

  // ---------------------------------------------------------------------------
  // Combinational decode / issue / response
  // ---------------------------------------------------------------------------
  bus_tgt_e    w_dec_tgt;
  logic        w_cnt_zero;
  logic        w_issue_ok;
  logic        w_ram_req;
  logic        w_per_req;
  logic        w_err_req;
  logic        w_grant;
  logic        w_sel_rvalid;
  logic [31:0] w_sel_rdata;
  logic        w_sel_err;
  logic        w_rsp;
  logic        w_spurious;

  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    w_dec_tgt    = decode_tgt(m_addr_i, ADDR_WIDTH, PERIPH_BASE, PERIPH_MASK);
    w_cnt_zero   = (r_count == '0);
    w_sel_rvalid = 1'b0;
    w_sel_rdata  = '0;
    w_sel_err    = 1'b0;

    // Holding reset low also blocks issue, so nothing leaks out during reset.
    w_issue_ok = rst_ni
              && (r_count < CNT_W'(MAX_OUTSTANDING))
              && (w_cnt_zero || (w_dec_tgt == r_tgt));

    w_ram_req = m_req_i && w_issue_ok && (w_dec_tgt == TGT_RAM);
    w_per_req = m_req_i && w_issue_ok && (w_dec_tgt == TGT_PER);
    w_err_req = m_req_i && w_issue_ok && (w_dec_tgt == TGT_ERR);

    // The internal error responder always accepts immediately.
    w_grant = (w_ram_req && ram_gnt_i) || (w_per_req && per_gnt_i) || w_err_req;

    unique case (r_tgt)
      TGT_RAM: begin
        w_sel_rvalid = ram_rvalid_i;
        w_sel_rdata  = ram_rdata_i;
      end
      TGT_PER: begin
        w_sel_rvalid = per_rvalid_i;
        w_sel_rdata  = per_rdata_i;
        w_sel_err    = per_err_i;
      end
      TGT_ERR: begin
        w_sel_rvalid = r_err_pending;
        w_sel_err    = 1'b1;
      end
      default: ;
    endcase

    // Only a response from the selected target with something in flight is
    // forwarded; anything else is dropped and flagged.
    w_rsp      = rst_ni && !w_cnt_zero && w_sel_rvalid;
    w_spurious = (ram_rvalid_i && (w_cnt_zero || (r_tgt != TGT_RAM)))
              || (per_rvalid_i && (w_cnt_zero || (r_tgt != TGT_PER)));
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count       <= '0;
      r_tgt         <= TGT_RAM;
      r_err_pending <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tgt <= w_dec_tgt;
      end
      r_err_pending <= w_err_req;

      unique case ({w_grant, w_rsp})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_spurious) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_gnt_o     = w_grant;
  assign m_rvalid_o  = w_rsp;
  assign m_rdata_o   = w_rsp ? w_sel_rdata : '0;
  assign m_err_o     = w_rsp && w_sel_err;

  assign ram_req_o   = w_ram_req;
  assign ram_addr_o  = m_addr_i[ADDR_WIDTH-1:0];
  assign ram_we_o    = m_we_i;
  assign ram_be_o    = m_be_i;
  assign ram_wdata_o = m_wdata_i;

  assign per_req_o   = w_per_req;
  assign per_addr_o  = m_addr_i;
  assign per_we_o    = m_we_i;
  assign per_be_o    = m_be_i;
  assign per_wdata_o = m_wdata_i;

  assign outstanding_o = r_count;
  assign proto_err_o   = r_proto_err;

endmodule : data_bus_router
